abs: RTL and testbench

//   Registered absolute-value unit for the GRNG core datapath.

---
 rtl/grng_pkg.sv | 11 +
 rtl/abs.sv | 31 +++
 tb/tb_abs.sv | 103 ++++++++++
 3 files changed

// File: rtl/grng_pkg.sv
// Shared GRNG datapath constants and fixed-point types.
// Q3.28 signed samples and UQ4.28 unsigned magnitudes.
package grng_pkg;

   localparam int DATA_W = 32;
   localparam int FRAC_W = 28;

   typedef logic signed [DATA_W-1:0] q3_28_t;
   typedef logic        [DATA_W-1:0] uq4_28_t;

endpackage

// File: rtl/abs.sv
// Registered absolute value: Q3.28 in, UQ4.28 magnitude out, 1-cycle latency.
// Ports: clk, rst (sync, active-high), value (Q3.28), abs_value (UQ4.28).
module abs
   import grng_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] value,
   output logic [DATA_W-1:0] abs_value
);

   q3_28_t  sample;
   uq4_28_t neg;
   uq4_28_t mag;

   assign sample = q3_28_t'(value);

   // Two's-complement negate. The result is read as unsigned, so the
   // most-negative input maps to 2^(DATA_W-1) and does not wrap.
   assign neg = uq4_28_t'(~sample) + uq4_28_t'(1);
   assign mag = sample[DATA_W-1] ? neg : uq4_28_t'(sample);

   always_ff @(posedge clk) begin
      if (rst) begin
         abs_value <= '0;
      end else begin
         abs_value <= mag;
      end
   end

endmodule

// File: tb/tb_abs.sv
// Testbench for abs: reset, directed vectors, mid-stream reset, random.
// Drives on the falling edge, checks 1 time unit after the rising edge.
module tb_abs;

   logic        clk;
   logic        rst;
   logic [31:0] value;
   logic [31:0] abs_value;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic [31:0] din;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [10];

   abs dut (
      .clk       (clk),
      .rst       (rst),
      .value     (value),
      .abs_value (abs_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one sample with the given reset, then check after the edge.
   task automatic step(input logic r,
                       input logic [31:0] v,
                       input logic [31:0] exp,
                       input string name);
      @(negedge clk);
      rst   = r;
      value = v;
      @(posedge clk);
      #1;
      check(name, abs_value, exp);
   endtask

   initial begin
      logic [31:0]        rv;
      logic signed [32:0] v33;
      logic signed [32:0] r33;
      logic [31:0]        rexp;

      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      value        = 32'hFFFF_FFFB;

      vecs[0] = '{32'h8000_0000, 32'h8000_0000};
      vecs[1] = '{32'h0000_0000, 32'h0000_0000};
      vecs[2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
      vecs[3] = '{32'hF000_0000, 32'h1000_0000};
      vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001};
      vecs[5] = '{32'hFFFF_FFFD, 32'h0000_0003};
      vecs[6] = '{32'h0000_0007, 32'h0000_0007};
      vecs[7] = '{32'hC000_0000, 32'h4000_0000};
      vecs[8] = '{32'h8000_0001, 32'h7FFF_FFFF};
      vecs[9] = '{32'h1000_0000, 32'h1000_0000};

      // Reset held two edges with -5 on the input, then released.
      step(1'b1, 32'hFFFF_FFFB, 32'h0, "reset_edge1");
      step(1'b1, 32'hFFFF_FFFB, 32'h0, "reset_edge2");
      step(1'b0, 32'hFFFF_FFFB, 32'h5, "reset_release");

      // Back-to-back samples, one per cycle.
      for (int i = 0; i < 10; i++) begin
         step(1'b0, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Reset mid-stream wins over the most-negative input.
      step(1'b1, 32'h8000_0000, 32'h0, "mid_reset");
      step(1'b0, 32'h8000_0000, 32'h8000_0000, "after_mid_reset");
      step(1'b0, 32'hFFFF_FFFF, 32'h1, "after_mid_reset2");

      // Random values against a 33-bit signed reference.
      for (int i = 0; i < 10000; i++) begin
         rv   = $urandom;
         v33  = {rv[31], rv};
         r33  = (v33 < 0) ? -v33 : v33;
         rexp = r33[31:0];
         step(1'b0, rv, rexp, "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
